// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the pipeline clock run-control sequencer:
// mode encodings, FSM state type, default debounce length, scale helper.
package cpu_clk_pkg;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    RUN_S   = 2'd1,
    BURST_S = 2'd2,
    BREAK_S = 2'd3
  } state_t;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  // Prescaler compare limit; a scale of 0 behaves like 1.
  function automatic logic [31:0] scale_limit(
    input logic [31:0] scale
  );
    return (scale == 32'd0) ? 32'd0 : scale - 32'd1;
  endfunction

endpackage

// File: rtl/step_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability debounce and
// rising-edge press pulse. Ports: clk, rst, button in; press out (1 cycle).
module step_debounce #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic sync1;
  logic sync2;
  logic level;
  logic level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      // Accept a new level only after CYCLES consecutive
      // cycles of disagreement with the current one.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
      level_q <= level;
      press   <= level & ~level_q;
    end
  end

endmodule

// File: rtl/cpu_clock_controller.sv
// Run-control sequencer producing the pipeline clock-enable tick.
// Ports: RawClock, reset, ClockScale, Mode, StepButton, BurstCount,
// BreakEnable, BreakAddr, PC in; tick, Running, BreakHit, TickCount out.
module cpu_clock_controller
  import cpu_clk_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int BURST_W         = 16
) (
  input  logic               RawClock,
  input  logic               reset,
  input  logic [31:0]        ClockScale,
  input  logic [1:0]         Mode,
  input  logic               StepButton,
  input  logic [BURST_W-1:0] BurstCount,
  input  logic               BreakEnable,
  input  logic [31:0]        BreakAddr,
  input  logic [31:0]        PC,
  output logic               tick,
  output logic               Running,
  output logic               BreakHit,
  output logic [31:0]        TickCount
);

  localparam logic [BURST_W-1:0] ONE = BURST_W'(1);

  state_t state;
  state_t state_n;
  logic [31:0] q;
  logic [31:0] q_n;
  logic [BURST_W-1:0] remaining;
  logic [BURST_W-1:0] rem_n;
  logic armed;
  logic armed_n;
  logic tick_n;
  logic press;
  logic fire;
  logic bp;

  step_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk   (RawClock),
    .rst   (reset),
    .button(StepButton),
    .press (press)
  );

  assign fire = (q >= scale_limit(ClockScale));
  assign bp   = BreakEnable && (PC == BreakAddr);

  always_comb begin
    state_n = state;
    q_n     = q;
    rem_n   = remaining;
    armed_n = armed;
    tick_n  = 1'b0;
    unique case (state)
      IDLE_S: begin
        q_n = '0;
        if (Mode != MODE_BURST) armed_n = 1'b0;
        unique case (Mode)
          MODE_RUN: state_n = RUN_S;
          MODE_BURST: begin
            if (!armed) begin
              rem_n   = BurstCount;
              armed_n = 1'b1;
              state_n = BURST_S;
            end
          end
          MODE_STEP: tick_n = press;
          MODE_HALT: ;
        endcase
      end
      RUN_S: begin
        if (Mode != MODE_RUN) begin
          state_n = IDLE_S;
          q_n     = '0;
        end else if (fire) begin
          q_n = '0;
          if (bp) state_n = BREAK_S;
          else    tick_n  = 1'b1;
        end else begin
          q_n = q + 32'd1;
        end
      end
      BURST_S: begin
        if (Mode != MODE_BURST || remaining == '0) begin
          state_n = IDLE_S;
          q_n     = '0;
        end else if (fire) begin
          q_n = '0;
          // Breakpoint wins over the final burst tick.
          if (bp) begin
            state_n = BREAK_S;
          end else begin
            tick_n = 1'b1;
            rem_n  = remaining - ONE;
            if (remaining == ONE) state_n = IDLE_S;
          end
        end else begin
          q_n = q + 32'd1;
        end
      end
      BREAK_S: begin
        q_n = '0;
        if (Mode == MODE_HALT || Mode == MODE_STEP) begin
          state_n = IDLE_S;
        end else if (press) begin
          // Step-over: one tick without the address compare.
          tick_n = 1'b1;
          if (Mode == MODE_RUN) begin
            state_n = RUN_S;
          end else begin
            if (remaining != '0) rem_n = remaining - ONE;
            state_n = (remaining > ONE) ? BURST_S : IDLE_S;
          end
        end
      end
    endcase
  end

  always_ff @(posedge RawClock or posedge reset) begin
    if (reset) begin
      state     <= IDLE_S;
      q         <= '0;
      remaining <= '0;
      armed     <= 1'b0;
      tick      <= 1'b0;
      Running   <= 1'b0;
      BreakHit  <= 1'b0;
      TickCount <= '0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      remaining <= rem_n;
      armed     <= armed_n;
      tick      <= tick_n;
      Running   <= (state_n == RUN_S) || (state_n == BURST_S);
      BreakHit  <= (state_n == BREAK_S);
      TickCount <= TickCount + {31'd0, tick_n};
    end
  end

endmodule

// File: doc/cpu_clock_controller.md
# cpu_clock_controller

Run-control sequencer for the five-stage pipeline's clock. Generates a registered, one-`RawClock`-cycle clock-enable pulse (`tick`) that advances the pipeline. The pulse rate is set by a programmable prescaler. Supported modes are halt, free-run, single-step (debounced push button) and counted burst, with a PC breakpoint that stops free-run or burst.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: cycles the synchronized button must be stable before a level change is accepted.
- `BURST_W`, default 16: width of the burst counter.

Ports (one clock; reset is asynchronous and active-high):
- `RawClock`  in  1  system clock; all state on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ClockScale`  in  32  tick period in `RawClock` cycles; 0 treated as 1.
- `Mode`  in  2  00 HALT, 01 RUN, 10 STEP, 11 BURST; sampled every cycle.
- `StepButton`  in  1  raw asynchronous push button, active-high.
- `BurstCount`  in  `BURST_W`  ticks to issue per BURST arming.
- `BreakEnable`  in  1  enables the PC breakpoint.
- `BreakAddr`  in  32  breakpoint address.
- `PC`  in  32  current fetch PC from the pipeline.
- `tick`  out  1  pipeline clock enable, high for exactly one cycle.
- `Running`  out  1  high in RUN_S or BURST_S.
- `BreakHit`  out  1  high while in BREAK_S.
- `TickCount`  out  32  total ticks issued since reset, wraps at 2^32.

## Operation
- States: IDLE_S, RUN_S, BURST_S, BREAK_S.
- Reset values: state IDLE_S; prescaler 0; burst remaining 0; burst armed 0; `tick` 0; `Running` 0; `BreakHit` 0; `TickCount` 0. Debouncer level 0.
- Prescaler `q` counts only in RUN_S/BURST_S. A tick fires when `q >= max(ClockScale,1)-1`, and `q` is then cleared. `q` is cleared on every state entry.
- IDLE_S:
  - `Mode`=RUN goes to RUN_S.
  - `Mode`=BURST with armed=0 loads remaining=`BurstCount`, sets armed=1 and goes to BURST_S.
  - `Mode`=STEP: each debounced press pulse gives one tick. The breakpoint is not checked.
  - `Mode`≠BURST clears armed.
- RUN_S: ticks at the prescaled rate. `Mode`≠RUN returns to IDLE_S with no further tick.
- BURST_S:
  - Each tick decrements remaining.
  - When remaining reaches 0, go to IDLE_S; armed stays 1 until `Mode` leaves BURST.
  - `BurstCount`=0 returns to IDLE_S with zero ticks.
  - `Mode`≠BURST aborts to IDLE_S.
- Breakpoint: in RUN_S/BURST_S, on a cycle where the prescaler would fire with `BreakEnable`=1 and `PC`==`BreakAddr`, the tick is suppressed and the block goes to BREAK_S. Remaining is not decremented.
- BREAK_S:
  - `Mode`=HALT or STEP goes to IDLE_S.
  - A press pulse issues one tick with the compare masked (step-over), then returns to RUN_S if `Mode`=RUN, or to BURST_S if `Mode`=BURST with remaining>0 (decremented), else IDLE_S.
- Simultaneous events:
  - Mode change outranks prescaler fire; a tick is never issued on the cycle the mode is left.
  - Breakpoint outranks burst completion.
- `TickCount` increments on every cycle `tick`=1.

## Timing
- `tick`, `Running` and `BreakHit` are registered and glitch-free.
- In RUN_S, the first tick occurs `max(ClockScale,1)` cycles after state entry. The steady-state period is `max(ClockScale,1)` cycles, so `ClockScale`≤1 gives `tick` high every cycle.
- Button path:
  - 2-FF synchronizer, then debounce of `DEBOUNCE_CYCLES` stable cycles.
  - A rising edge of the debounced level gives a 1-cycle press pulse.
  - `tick` follows the press pulse by 1 cycle.
  - Button-to-tick latency is `DEBOUNCE_CYCLES`+4 cycles.
- `ClockScale` changes take effect at the next compare; `q` is not reset.
- `reset` mid-operation: all outputs reach reset values asynchronously and `tick` deasserts immediately. Armed is cleared, so BURST re-arms if `Mode`=BURST after release.

## Structure
- Shared package `cpu_clk_pkg`: mode encodings (`MODE_HALT/RUN/STEP/BURST`), state enum, default `DEBOUNCE_CYCLES`.
- Sub-module `step_debounce`: synchronizer, debounce counter, press-pulse output. It is reused for other board buttons.
- Top: state machine, prescaler, burst counter, breakpoint compare, tick counter.

## Test plan
- RUN, `ClockScale`=4, reset released -> `tick` at cycles 4, 8, 12 after entry; `TickCount`=3 at cycle 12; `Running`=1.
- BURST, `BurstCount`=3, `ClockScale`=2 -> exactly 3 ticks, 2 cycles apart, then IDLE_S. Holding BURST gives no more ticks; HALT then BURST gives 3 more.
- STEP, `DEBOUNCE_CYCLES`=8, button bouncing 5 toggles then held 20 cycles -> exactly one tick, 12 cycles after the stable edge.
- RUN, `BreakEnable`=1, `BreakAddr`=0x10, `PC` reaches 0x10 -> tick suppressed, `BreakHit`=1. One press -> one tick, back to RUN_S, `BreakHit`=0.
- RUN `ClockScale`=0 and then 1 -> `tick` high every cycle. Mode to HALT on a fire cycle -> no tick that cycle.
- Assert `reset` mid-BURST -> `tick`=0 the same cycle, `TickCount`=0; after release with `Mode`=BURST the full `BurstCount` is reissued.
